// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, default widths and opcode constants.
// ST_HALT exists only when FETCH_HALT_ON_NOP_EN is defined.
package cpu_pkg;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned IMM_W       = 16;
  localparam int unsigned CNT_W       = 16;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_VALID = 2'd2;
`ifdef FETCH_HALT_ON_NOP_EN
  localparam fetch_state_t ST_HALT  = 2'd3;
`endif

  // Opcodes that redirect fetch through the PC-relative target adder.
  function automatic logic is_redirect_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BLE);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// PC-relative target adder: target = ir_pc + 1 + sext(imm16), modulo 2^PC_W.
// Combinational; shared with the branch comparator.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0]  ir_pc,
  input  logic [IMM_W-1:0] imm16,
  output logic [PC_W-1:0]  target
);

  logic [PC_W-1:0] imm_ext;

  // A size cast of a signed operand sign-extends (or truncates) to PC_W.
  assign imm_ext = PC_W'($signed(imm16));
  assign target  = ir_pc + PC_W'(1) + imm_ext;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, captures instruction-memory data into ir and counts fetches.
// Optional feature macro FETCH_HALT_ON_NOP_EN: an all-zero word halts fetch until reset.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               redirect,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  output logic [CNT_W-1:0]   fetch_count,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic               ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]    redirect_target;

  pc_target_calc #(
    .PC_W (PC_W)
  ) u_pc_target_calc (
    .ir_pc  (ir_pc_q),
    .imm16  (ir_q[IMM_W-1:0]),
    .target (redirect_target)
  );

`ifdef FETCH_HALT_ON_NOP_EN
  logic halted_q, halted_d;
  logic is_nop;

  assign is_nop = (imem_instr == '0);
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    ir_pc_d       = ir_pc_q;
    ir_d          = ir_q;
    fetch_count_d = fetch_count_q;
    ir_valid_d    = ir_valid_q;
`ifdef FETCH_HALT_ON_NOP_EN
    halted_d      = halted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d          = imem_instr;
        ir_pc_d       = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_W'(1);
        fetch_count_d = fetch_count_q + CNT_W'(1);
        ir_valid_d    = 1'b1;
`ifdef FETCH_HALT_ON_NOP_EN
        if (is_nop) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_VALID;
        end
`else
        state_d       = ST_VALID;
`endif
      end
      ST_VALID: begin
        // Redirect and request in one cycle: the new FETCH sees the redirected PC.
        if (redirect) begin
          fetch_pc_d = redirect_target;
        end
        if (fetch_req) begin
          state_d    = ST_FETCH;
          ir_valid_d = 1'b0;
        end
      end
`ifdef FETCH_HALT_ON_NOP_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= '0;
      ir_pc_q       <= '0;
      ir_q          <= '0;
      fetch_count_q <= '0;
      ir_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      ir_pc_q       <= ir_pc_d;
      ir_q          <= ir_d;
      fetch_count_q <= fetch_count_d;
      ir_valid_q    <= ir_valid_d;
    end
  end

`ifdef FETCH_HALT_ON_NOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign imem_pc     = fetch_pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a scoreboard of expected captures is filled
// as fetches are issued and drained when the captured word appears in ir.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic [15:0] fetch_count;
  logic        halted;

  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ir;
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model of the architectural fetch state.
  logic [15:0] m_pc;
  logic [15:0] m_ir_pc;
  logic [15:0] m_cnt;
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc[7:0]];

  instr_fetch_unit #(
    .PC_W    (16),
    .INSTR_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .fetch_count (fetch_count),
    .halted      (halted)
  );

  task automatic model_reset();
    m_pc = 16'h0; m_ir_pc = 16'h0; m_cnt = 16'h0; m_ir = 32'h0;
    sb.delete();
  endtask

  // Request edge; returns at the negedge inside the FETCH cycle. noise holds both
  // controls high through FETCH, where they must have no effect.
  task automatic issue(input bit redir, input bit noise);
    exp_t e;
    @(negedge clk);
    fetch_req = 1'b1;
    redirect  = redir;
    if (redir) m_pc = m_ir_pc + 16'd1 + m_ir[15:0];
    e.ir  = mem[m_pc[7:0]];
    e.pc  = m_pc;
    e.cnt = m_cnt + 16'd1;
    sb.push_back(e);
    m_ir = e.ir; m_ir_pc = m_pc; m_pc = m_pc + 16'd1; m_cnt = e.cnt;
    @(negedge clk);
    fetch_req = noise;
    redirect  = noise;
  endtask

  task automatic capture(output exp_t e);
    @(negedge clk);
    fetch_req = 1'b0;
    redirect  = 1'b0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=0 entries exp=1");
      e.ir = 'x; e.pc = 'x; e.cnt = 'x;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
    checks++; if (ir_pc !== 16'h0) begin failures++; $display("FAIL reset_ir_pc got=%h exp=0", ir_pc); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
    checks++; if (imem_pc !== 16'h0) begin failures++; $display("FAIL reset_imem_pc got=%h exp=0", imem_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_fetch();
    exp_t e;
    issue(1'b0, 1'b0);
    checks++; if (imem_pc !== 16'h0) begin failures++; $display("FAIL first_fetch_addr got=%h exp=0", imem_pc); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL first_fetch_valid_low got=%b exp=0", ir_valid); end
    capture(e);
    checks++; if (ir !== e.ir) begin failures++; $display("FAIL first_ir got=%h exp=%h", ir, e.ir); end
    checks++; if (ir_pc !== e.pc) begin failures++; $display("FAIL first_ir_pc got=%h exp=%h", ir_pc, e.pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL first_ir_valid got=%b exp=1", ir_valid); end
    checks++; if (fetch_count !== e.cnt) begin failures++; $display("FAIL first_count got=%h exp=%h", fetch_count, e.cnt); end
    checks++; if (imem_pc !== 16'd1) begin failures++; $display("FAIL first_next_pc got=%h exp=1", imem_pc); end
  endtask

  task automatic test_redirect_with_fetch();
    exp_t e;
    issue(1'b0, 1'b0);
    capture(e);
    checks++; if (ir_pc !== e.pc) begin failures++; $display("FAIL rf_ir_pc1 got=%h exp=%h", ir_pc, e.pc); end
    issue(1'b1, 1'b0);
    checks++; if (imem_pc !== 16'd12) begin failures++; $display("FAIL rf_addr12 got=%h exp=000c", imem_pc); end
    capture(e);
    checks++; if (ir !== e.ir) begin failures++; $display("FAIL rf_ir12 got=%h exp=%h", ir, e.ir); end
    issue(1'b1, 1'b1);
    checks++; if (imem_pc !== 16'd10) begin failures++; $display("FAIL rf_addr10 got=%h exp=000a", imem_pc); end
    capture(e);
    checks++; if (ir_pc !== e.pc) begin failures++; $display("FAIL rf_ir_pc10 got=%h exp=%h", ir_pc, e.pc); end
    checks++; if (imem_pc !== m_pc) begin failures++; $display("FAIL rf_fetch_noise got=%h exp=%h", imem_pc, m_pc); end
    checks++; if (fetch_count !== e.cnt) begin failures++; $display("FAIL rf_count got=%h exp=%h", fetch_count, e.cnt); end
  endtask

  task automatic test_redirect_then_fetch();
    exp_t e;
    issue(1'b1, 1'b0);
    capture(e);
    checks++; if (ir_pc !== 16'd18) begin failures++; $display("FAIL rtf_ir_pc18 got=%h exp=0012", ir_pc); end
    @(negedge clk);
    redirect = 1'b1;
    m_pc = m_ir_pc + 16'd1 + m_ir[15:0];
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (imem_pc !== 16'd21) begin failures++; $display("FAIL rtf_target got=%h exp=0015", imem_pc); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL rtf_still_valid got=%b exp=1", ir_valid); end
    issue(1'b0, 1'b0);
    checks++; if (imem_pc !== 16'd21) begin failures++; $display("FAIL rtf_addr21 got=%h exp=0015", imem_pc); end
    capture(e);
    checks++; if (ir_pc !== e.pc) begin failures++; $display("FAIL rtf_ir_pc21 got=%h exp=%h", ir_pc, e.pc); end
  endtask

  task automatic test_wrap();
    exp_t e;
    issue(1'b1, 1'b0);
    capture(e);
    checks++; if (ir_pc !== 16'h0000) begin failures++; $display("FAIL wrap_ir_pc0 got=%h exp=0000", ir_pc); end
    issue(1'b1, 1'b0);
    checks++; if (imem_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_target got=%h exp=ffff", imem_pc); end
    capture(e);
    checks++; if (ir_pc !== e.pc) begin failures++; $display("FAIL wrap_ir_pc got=%h exp=%h", ir_pc, e.pc); end
    checks++; if (ir !== e.ir) begin failures++; $display("FAIL wrap_ir got=%h exp=%h", ir, e.ir); end
    checks++; if (imem_pc !== 16'h0000) begin failures++; $display("FAIL wrap_next_pc got=%h exp=0000", imem_pc); end
    checks++; if (fetch_count !== e.cnt) begin failures++; $display("FAIL wrap_count got=%h exp=%h", fetch_count, e.cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    issue(1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rmf_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL rmf_ir got=%h exp=0", ir); end
    checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL rmf_count got=%h exp=0", fetch_count); end
    checks++; if (imem_pc !== 16'h0) begin failures++; $display("FAIL rmf_imem_pc got=%h exp=0", imem_pc); end
    checks++; if (ir_pc !== 16'h0) begin failures++; $display("FAIL rmf_ir_pc got=%h exp=0", ir_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Redirect in IDLE must be ignored; with ir=0 a wrongly applied one would yield 1.
    @(negedge clk);
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (imem_pc !== 16'h0) begin failures++; $display("FAIL idle_redirect got=%h exp=0", imem_pc); end
  endtask

  task automatic test_nop();
    exp_t e;
    logic [15:0] cnt_before;
    issue(1'b0, 1'b0);
    capture(e);
    issue(1'b1, 1'b0);
    checks++; if (imem_pc !== 16'd22) begin failures++; $display("FAIL nop_addr got=%h exp=0016", imem_pc); end
    capture(e);
    checks++; if (ir !== 32'h0) begin failures++; $display("FAIL nop_ir got=%h exp=0", ir); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL nop_ir_valid got=%b exp=1", ir_valid); end
    checks++; if (fetch_count !== e.cnt) begin failures++; $display("FAIL nop_count got=%h exp=%h", fetch_count, e.cnt); end
`ifdef FETCH_HALT_ON_NOP_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL nop_halted got=%b exp=1", halted); end
    cnt_before = m_cnt;
    @(negedge clk);
    fetch_req = 1'b1; redirect = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0; redirect = 1'b0;
    @(negedge clk);
    checks++; if (fetch_count !== cnt_before) begin failures++; $display("FAIL halt_count got=%h exp=%h", fetch_count, cnt_before); end
    checks++; if (imem_pc !== 16'd23) begin failures++; $display("FAIL halt_imem_pc got=%h exp=0017", imem_pc); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", halted); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL halt_ir_valid got=%b exp=1", ir_valid); end
`else
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL nop_halted got=%b exp=0", halted); end
    cnt_before = m_cnt + 16'd1;
    issue(1'b0, 1'b0);
    capture(e);
    checks++; if (ir_pc !== 16'd23) begin failures++; $display("FAIL after_nop_ir_pc got=%h exp=0017", ir_pc); end
    checks++; if (ir !== e.ir) begin failures++; $display("FAIL after_nop_ir got=%h exp=%h", ir, e.ir); end
    checks++; if (fetch_count !== cnt_before) begin failures++; $display("FAIL after_nop_count got=%h exp=%h", fetch_count, cnt_before); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | i;
    mem[0]   = 32'hE400_FFFF;
    mem[1]   = 32'h8400_000A;        // BNE, imm 10 -> 12
    mem[12]  = 32'h8400_FFFD;        // BNE, imm -3 -> 10
    mem[10]  = 32'h0400_0007;        // J, imm 7 -> 18
    mem[18]  = 32'h0400_0002;        // J, imm 2 -> 21
    mem[21]  = 32'h0400_FFEA;        // J, imm -22 -> 0
    mem[255] = 32'h2468_ACE0;
    model_reset();

    test_reset();
    test_first_fetch();
    test_redirect_with_fetch();
    test_redirect_then_fetch();
    mem[0] = 32'h0400_FFFE;          // J, imm -2 -> 0xFFFF
    test_wrap();
    mem[0] = 32'h0C00_0015;
    test_reset_mid_fetch();
    mem[0]  = 32'h0400_0015;         // J, imm 21 -> 22
    mem[22] = 32'h0000_0000;
    mem[23] = 32'h1357_9BDF;
    test_nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
